// File: rtl/turn_sequencer.sv
// Turn sequencer for the chicken board game. It synchronises the buttons, strobes accepted
// flips into check_win, waits for the datapath to settle, and then keeps the turn, passes it, or ends the game.
module turn_sequencer #(
   parameter int NUM_PLAYERS  = 3,
   parameter int GOAL_POS     = 24,
   parameter int SETTLE_CYC   = 2,
   parameter int TURN_TIMEOUT = 0,
   parameter int TO_W         = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn_i,
   input  logic       flip_btn_i,
   input  logic       match_i,
   input  logic [4:0] pos_data_i,
   output logic [1:0] turn_o,
   output logic       flip_pulse_o,
   output logic       busy_o,
   output logic       game_over_o,
   output logic [1:0] winner_o
);

   localparam int              SC_W         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SC_W-1:0] SC_LAST      = SC_W'(SETTLE_CYC - 1);
   localparam int              TO_LAST_I    = (TURN_TIMEOUT > 0) ? (TURN_TIMEOUT - 1) : 0;
   localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TO_LAST_I);
   localparam logic [TO_W-1:0] TO_MAX       = {TO_W{1'b1}};
   localparam bit              TO_EN        = (TURN_TIMEOUT != 0);
   localparam bit              WIN_POSSIBLE = (GOAL_POS <= 31);
   localparam logic [4:0]      GOAL         = 5'(GOAL_POS);
   localparam logic [1:0]      LAST_PLAYER  = 2'(NUM_PLAYERS);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_FLIP = 3'd1,
      S_SETTLE    = 3'd2,
      S_DECIDE    = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   function automatic logic [1:0] next_player(input logic [1:0] t);
      next_player = (t == LAST_PLAYER) ? 2'd1 : (t + 2'd1);
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      turn_q, turn_d;
   logic [1:0]      winner_q, winner_d;
   logic            pulse_q, pulse_d;
   logic            busy_q, busy_d;
   logic            game_over_q, game_over_d;
   logic [SC_W-1:0] settle_q, settle_d;
   logic [TO_W-1:0] timer_q, timer_d;
   logic [2:0]      start_sync_q, flip_sync_q;
   logic            start_ev_s, flip_ev_s, win_s;

   // Two synchroniser stages plus one history stage per button for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_sync_q <= 3'b000;
         flip_sync_q  <= 3'b000;
      end else begin
         start_sync_q <= {start_sync_q[1:0], start_btn_i};
         flip_sync_q  <= {flip_sync_q[1:0], flip_btn_i};
      end
   end

   assign start_ev_s = start_sync_q[1] & ~start_sync_q[2];
   assign flip_ev_s  = flip_sync_q[1] & ~flip_sync_q[2];
   assign win_s      = WIN_POSSIBLE && (pos_data_i >= GOAL);

   // State, turn, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         turn_q      <= 2'd0;
         winner_q    <= 2'd0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
         game_over_q <= 1'b0;
         settle_q    <= {SC_W{1'b0}};
         timer_q     <= {TO_W{1'b0}};
      end else begin
         state_q     <= state_d;
         turn_q      <= turn_d;
         winner_q    <= winner_d;
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
         game_over_q <= game_over_d;
         settle_q    <= settle_d;
         timer_q     <= timer_d;
      end
   end

   // Next-state logic; outputs are derived from the next state so they come straight off registers
   always_comb begin
      state_d  = state_q;
      turn_d   = turn_q;
      winner_d = winner_q;
      pulse_d  = 1'b0;
      settle_d = settle_q;
      timer_d  = timer_q;
      case (state_q)
         S_IDLE: begin
            if (start_ev_s) begin
               state_d = S_WAIT_FLIP;
               turn_d  = 2'd1;
               timer_d = {TO_W{1'b0}};
            end else begin
               turn_d = 2'd0;
            end
         end
         S_WAIT_FLIP: begin
            // A flip arriving on the expiry cycle takes priority over the auto-pass
            if (flip_ev_s) begin
               state_d  = S_SETTLE;
               pulse_d  = 1'b1;
               settle_d = {SC_W{1'b0}};
            end else if (TO_EN && (timer_q == TO_LAST)) begin
               turn_d  = next_player(turn_q);
               timer_d = {TO_W{1'b0}};
            end else if (timer_q != TO_MAX) begin
               timer_d = timer_q + TO_W'(1);
            end else begin
               timer_d = timer_q;
            end
         end
         S_SETTLE: begin
            if (settle_q == SC_LAST) begin
               state_d = S_DECIDE;
            end else begin
               settle_d = settle_q + SC_W'(1);
            end
         end
         S_DECIDE: begin
            timer_d = {TO_W{1'b0}};
            if (match_i && win_s) begin
               state_d  = S_DONE;
               winner_d = turn_q;
            end else if (match_i) begin
               state_d = S_WAIT_FLIP;
            end else begin
               state_d = S_WAIT_FLIP;
               turn_d  = next_player(turn_q);
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
            turn_d  = 2'd0;
         end
      endcase
      busy_d      = (state_d == S_SETTLE) || (state_d == S_DECIDE);
      game_over_d = (state_d == S_DONE);
   end

   assign turn_o       = turn_q;
   assign flip_pulse_o = pulse_q;
   assign busy_o       = busy_q;
   assign game_over_o  = game_over_q;
   assign winner_o     = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: two instances (timeout off / timeout 8) checked every cycle
// against an event-timestamp model, plus directed scenarios and a randomized soak.
module tb_turn_sequencer;

   localparam int NP   = 3;
   localparam int GOAL = 24;
   localparam int SC   = 2;

   logic       clk = 1'b0;
   logic       rst_n, start_btn, flip_btn, match;
   logic [4:0] pos_data;
   logic [1:0] turn0, turn8, winner0, winner8;
   logic       pulse0, pulse8, busy0, busy8, go0, go8;

   always #5 clk = ~clk;

   turn_sequencer #(.NUM_PLAYERS(NP), .GOAL_POS(GOAL), .SETTLE_CYC(SC), .TURN_TIMEOUT(0), .TO_W(24)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_btn_i(start_btn), .flip_btn_i(flip_btn),
      .match_i(match), .pos_data_i(pos_data), .turn_o(turn0), .flip_pulse_o(pulse0),
      .busy_o(busy0), .game_over_o(go0), .winner_o(winner0));

   turn_sequencer #(.NUM_PLAYERS(NP), .GOAL_POS(GOAL), .SETTLE_CYC(SC), .TURN_TIMEOUT(8), .TO_W(24)) dut8 (
      .clk(clk), .rst_n(rst_n), .start_btn_i(start_btn), .flip_btn_i(flip_btn),
      .match_i(match), .pos_data_i(pos_data), .turn_o(turn8), .flip_pulse_o(pulse8),
      .busy_o(busy8), .game_over_o(go8), .winner_o(winner8));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: remembers when each flip was accepted and when the current wait began
   int     to_cfg [2] = '{0, 8};
   int     m_turn [2], m_winner [2];
   longint m_flip [2], m_wait [2];
   bit     m_active [2], m_done [2], m_pulse [2];
   bit     hs [3], hf [3];
   longint edge_k = 0;
   int     pulse_cnt0 = 0;

   function automatic int nxt(input int t);
      return (t == NP) ? 1 : t + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_turn[i] = 0; m_winner[i] = 0; m_flip[i] = -1; m_wait[i] = 0;
         m_active[i] = 1'b0; m_done[i] = 1'b0; m_pulse[i] = 1'b0;
      end
      for (int j = 0; j < 3; j++) begin
         hs[j] = 1'b0; hf[j] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit sev, fev;
      sev = hs[1] & ~hs[2];
      fev = hf[1] & ~hf[2];
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start_btn;
      hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = flip_btn;
      for (int i = 0; i < 2; i++) begin
         m_pulse[i] = 1'b0;
         if (m_done[i]) begin
         end else if (!m_active[i]) begin
            if (sev) begin
               m_active[i] = 1'b1; m_turn[i] = 1; m_wait[i] = edge_k;
            end
         end else if (m_flip[i] >= 0) begin
            if (edge_k == m_flip[i] + SC + 1) begin
               m_flip[i] = -1;
               if (match && (int'(pos_data) >= GOAL)) begin
                  m_done[i] = 1'b1; m_winner[i] = m_turn[i];
               end else begin
                  m_wait[i] = edge_k;
                  if (!match) m_turn[i] = nxt(m_turn[i]);
               end
            end
         end else if (fev) begin
            m_flip[i] = edge_k; m_pulse[i] = 1'b1;
         end else if (to_cfg[i] != 0 && (edge_k - m_wait[i]) == to_cfg[i]) begin
            m_turn[i] = nxt(m_turn[i]); m_wait[i] = edge_k;
         end
      end
      edge_k++;
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         logic [1:0] t, w;
         logic p, b, g;
         t = (i == 0) ? turn0 : turn8;
         w = (i == 0) ? winner0 : winner8;
         p = (i == 0) ? pulse0 : pulse8;
         b = (i == 0) ? busy0 : busy8;
         g = (i == 0) ? go0 : go8;
         check_value($sformatf("d%0d_turn", i), 32'(t), 32'(m_turn[i]));
         check_value($sformatf("d%0d_pulse", i), 32'(p), 32'(m_pulse[i]));
         check_value($sformatf("d%0d_busy", i), 32'(b), (m_flip[i] >= 0) ? 32'd1 : 32'd0);
         check_value($sformatf("d%0d_over", i), 32'(g), 32'(m_done[i]));
         check_value($sformatf("d%0d_winner", i), 32'(w), m_done[i] ? 32'(m_winner[i]) : 32'd0);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      pulse_cnt0 += int'(pulse0);
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq [3] = '{2, 3, 1};
      int cnt;
      logic [1:0] saved;
      rst_n = 1'b0; start_btn = 1'b0; flip_btn = 1'b0; match = 1'b0; pos_data = 5'd0;
      model_reset();
      #2;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Start held 10 cycles gives a single start event
      start_btn = 1'b1; repeat (10) tick(); start_btn = 1'b0; repeat (2) tick();
      check_value("t1_turn", 32'(turn0), 32'd1);
      check_value("t1_over", 32'(go0), 32'd0);

      // Mismatching flips pass the turn 1->2->3->1
      match = 1'b0;
      for (int r = 0; r < 3; r++) begin
         flip_btn = 1'b1; repeat (2) tick(); flip_btn = 1'b0; repeat (6) tick();
         check_value("t2_turn", 32'(turn0), 32'(exp_seq[r]));
      end

      // Match below goal keeps the turn; a long hold is one flip
      match = 1'b1; pos_data = 5'd10; pulse_cnt0 = 0;
      flip_btn = 1'b1; repeat (50) tick(); flip_btn = 1'b0; repeat (4) tick();
      check_value("t3_pulses", 32'(pulse_cnt0), 32'd1);
      check_value("t3_turn", 32'(turn0), 32'd1);

      // Player 2 reaches the goal; later presses are ignored
      match = 1'b0;
      flip_btn = 1'b1; repeat (2) tick(); flip_btn = 1'b0; repeat (6) tick();
      match = 1'b1; pos_data = 5'd24;
      flip_btn = 1'b1; repeat (2) tick(); flip_btn = 1'b0; repeat (6) tick();
      check_value("t4_over", 32'(go0), 32'd1);
      check_value("t4_winner", 32'(winner0), 32'd2);
      pulse_cnt0 = 0;
      start_btn = 1'b1; repeat (3) tick(); start_btn = 1'b0;
      flip_btn = 1'b1; repeat (5) tick(); flip_btn = 1'b0; repeat (3) tick();
      check_value("t4_pulses", 32'(pulse_cnt0), 32'd0);
      check_value("t4_turn", 32'(turn0), 32'd2);
      check_value("t4_winner_held", 32'(winner0), 32'd2);

      // Timeout of 8 cycles, then a flip landing on the expiry cycle
      do_reset();
      match = 1'b0; pos_data = 5'd0; start_btn = 1'b1; cnt = 0;
      while (turn8 != 2'd1 && cnt < 20) begin tick(); cnt++; end
      check_value("t5_start", 32'(turn8), 32'd1);
      start_btn = 1'b0;
      repeat (7) tick();
      check_value("t5_hold", 32'(turn8), 32'd1);
      tick();
      check_value("t5_adv", 32'(turn8), 32'd2);
      cnt = 0;
      while (edge_k < m_wait[1] + 6 && cnt < 20) begin tick(); cnt++; end
      saved = turn8;
      flip_btn = 1'b1; repeat (3) tick();
      check_value("t5_flip_pulse", 32'(pulse8), 32'd1);
      check_value("t5_flip_turn", 32'(turn8), 32'(saved));
      flip_btn = 1'b0; repeat (6) tick();

      // A second press while busy is dropped
      do_reset();
      start_btn = 1'b1; repeat (4) tick(); start_btn = 1'b0;
      pulse_cnt0 = 0;
      flip_btn = 1'b1; tick(); flip_btn = 1'b0; tick();
      flip_btn = 1'b1; tick(); flip_btn = 1'b0; repeat (8) tick();
      check_value("t6_pulses", 32'(pulse_cnt0), 32'd1);

      // Reset while settling clears everything at once
      flip_btn = 1'b1; cnt = 0;
      while (busy0 != 1'b1 && cnt < 10) begin tick(); cnt++; end
      check_value("t6_busy_seen", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #1;
      check_value("t6_rst_turn", 32'(turn0), 32'd0);
      check_value("t6_rst_busy", 32'(busy0), 32'd0);
      check_value("t6_rst_pulse", 32'(pulse0), 32'd0);
      model_reset();
      flip_btn = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();

      // Randomized soak against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
         if ($urandom_range(0, 3) == 0) flip_btn = ~flip_btn;
         match    = 1'($urandom_range(0, 1));
         pos_data = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0 || (m_done[0] && m_done[1])) do_reset();
         else tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
